// File: rtl/acc_deserializer_pkg.sv
// Shared definitions for the serial ALU result path: collector FSM states,
// ALU result width and ALU opcode encodings.
package acc_deserializer_pkg;

  localparam int unsigned AluWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StStore,
    StDone
  } acc_state_e;

  localparam logic [3:0] AluOpAdd = 4'h0;
  localparam logic [3:0] AluOpSub = 4'h1;
  localparam logic [3:0] AluOpAnd = 4'h2;
  localparam logic [3:0] AluOpOr  = 4'h3;
  localparam logic [3:0] AluOpXor = 4'h4;
  localparam logic [3:0] AluOpSll = 4'h5;
  localparam logic [3:0] AluOpSrl = 4'h6;
  localparam logic [3:0] AluOpSlt = 4'h7;

endpackage

// File: rtl/acc_deserializer.sv
// Collects a serial, LSB-first ALU result into a parallel word and hands it
// to the register file, with stall, abort and result flags.
module acc_deserializer
  import acc_deserializer_pkg::*;
#(
  parameter int unsigned REG_WIDTH = AluWidth
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 wb_en,
  input  logic                 stall,
  input  logic                 abort,
  input  logic                 bit_in,
  output logic                 reg_shift_en,
  output logic                 reg_store_en,
  output logic [REG_WIDTH-1:0] acc_out,
  output logic [2:0]           bit_count,
  output logic                 busy,
  output logic                 done,
  output logic                 zero_flag,
  output logic                 msb_flag
);

  // Full-width counter so REG_WIDTH > 8 still finds its last bit; the
  // exported bit_count is its low three bits and so wraps modulo 8.
  localparam int unsigned CntW = ($clog2(REG_WIDTH + 1) > 3) ? $clog2(REG_WIDTH + 1) : 3;
  localparam logic [CntW-1:0] LastIdx = CntW'(REG_WIDTH - 1);

  acc_state_e           state_q, state_d;
  logic [REG_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 wb_q, wb_d;
  logic                 zero_q, zero_d;
  logic                 msb_q, msb_d;
  logic                 shift_en;

  assign shift_en = (state_q == StShift) & ~stall & ~abort;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    zero_d  = zero_q;
    msb_d   = msb_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          wb_d    = wb_en;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
        end else if (shift_en) begin
          acc_d = {bit_in, acc_q[REG_WIDTH-1:1]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastIdx) begin
            state_d = wb_q ? StStore : StDone;
            zero_d  = (acc_d == '0);
            msb_d   = bit_in;
          end
        end
      end
      StStore: state_d = abort ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      wb_q    <= 1'b0;
      zero_q  <= 1'b1;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      zero_q  <= zero_d;
      msb_q   <= msb_d;
    end
  end

  // Strobes are masked by abort so a cancelled op never reaches the regfile.
  assign reg_shift_en = shift_en;
  assign reg_store_en = (state_q == StStore) & ~abort;
  assign done         = (state_q == StDone) & ~abort;
  assign busy         = (state_q != StIdle);
  assign acc_out      = acc_q;
  assign bit_count    = cnt_q[2:0];
  assign zero_flag    = zero_q;
  assign msb_flag     = msb_q;

endmodule

// File: tb/tb_acc_deserializer.sv
// Randomized bench for acc_deserializer: each operation is predicted from its
// bit stream, stall window and abort point, then checked cycle by cycle.
module tb_acc_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn, start, wb_en, stall, abort, bit_in;
  logic         reg_shift_en, reg_store_en, busy, done, zero_flag, msb_flag;
  logic [W-1:0] acc_out;
  logic [2:0]   bit_count;

  int   n_pass = 0;
  int   n_total = 0;
  logic exp_zero = 1'b1;
  logic exp_msb = 1'b0;

  acc_deserializer #(.REG_WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .wb_en        (wb_en),
    .stall        (stall),
    .abort        (abort),
    .bit_in       (bit_in),
    .reg_shift_en (reg_shift_en),
    .reg_store_en (reg_store_en),
    .acc_out      (acc_out),
    .bit_count    (bit_count),
    .busy         (busy),
    .done         (done),
    .zero_flag    (zero_flag),
    .msb_flag     (msb_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // stall_after: accepted-bit count at which stall is held for stall_len cycles.
  // abort_on / restart_on: bit index on which abort / a second start is driven.
  task automatic run_op(input string tag, input logic wb, input logic [7:0] data,
                        input int stall_after, input int stall_len,
                        input int abort_on, input int restart_on);
    int   nb, k, stall_left, abort_k, exp_done_k, exp_store_k;
    int   shifts, stores, dones, done_k, stall_eff;
    logic st, ab, exp_shift, exp_busy;
    nb = 0; k = 0; stall_left = stall_len; abort_k = -1; exp_done_k = -1; exp_store_k = -1;
    shifts = 0; stores = 0; dones = 0; done_k = -1;
    @(posedge clk); #1;
    start = 1'b1; wb_en = wb; stall = 1'($urandom); abort = 1'b0; bit_in = 1'($urandom);
    while (1) begin
      k++;
      @(posedge clk); #1;
      start = 1'b0; wb_en = 1'($urandom); bit_in = 1'($urandom);
      st = 1'b0; ab = 1'b0;
      if (nb < W && abort_k < 0) begin
        if (stall_after == nb && stall_left > 0) begin
          st = 1'b1;
          stall_left--;
        end else begin
          bit_in = data[nb];
          if (abort_on == nb) ab = 1'b1;
        end
        if (restart_on == nb) begin
          start = 1'b1;
          wb_en = ~wb;
        end
      end
      stall = st; abort = ab;
      exp_shift = (nb < W) && (abort_k < 0) && !st && !ab;
      if (ab) abort_k = k;
      exp_busy = (abort_k < 0 || k <= abort_k) && (exp_done_k < 0 || k <= exp_done_k);
      @(negedge clk);
      check_eq({tag, ".shift_en"}, 32'(reg_shift_en), 32'(exp_shift));
      check_eq({tag, ".bit_count"}, 32'(bit_count), 32'(nb % 8));
      check_eq({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      check_eq({tag, ".store"}, 32'(reg_store_en), 32'(k == exp_store_k));
      check_eq({tag, ".done"}, 32'(done), 32'(k == exp_done_k));
      if (reg_shift_en) shifts++;
      if (reg_store_en) begin
        stores++;
        check_eq({tag, ".acc_at_store"}, 32'(acc_out), 32'(data));
      end
      if (done) begin
        dones++;
        done_k = k;
      end
      if (exp_shift) begin
        nb++;
        if (nb == W) begin
          exp_store_k = wb ? k + 1 : -1;
          exp_done_k  = wb ? k + 2 : k + 1;
        end
      end
      if (abort_k >= 0 && k >= abort_k + 2) break;
      if (exp_done_k >= 0 && k >= exp_done_k + 1) break;
      if (k > 40) begin
        check_eq({tag, ".timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    if (abort_on < 0) begin
      stall_eff = (stall_after >= 0 && stall_after < W) ? stall_len : 0;
      exp_zero = (data == 8'h00);
      exp_msb  = data[7];
      check_eq({tag, ".done_lat"}, 32'(done_k), 32'(1 + W + stall_eff + (wb ? 1 : 0)));
      check_eq({tag, ".n_shift"}, 32'(shifts), 32'(W));
      check_eq({tag, ".n_store"}, 32'(stores), wb ? 32'd1 : 32'd0);
      check_eq({tag, ".n_done"}, 32'(dones), 32'd1);
      check_eq({tag, ".acc_out"}, 32'(acc_out), 32'(data));
    end else begin
      check_eq({tag, ".n_store"}, 32'(stores), 32'd0);
      check_eq({tag, ".n_done"}, 32'(dones), 32'd0);
    end
    check_eq({tag, ".zero"}, 32'(zero_flag), 32'(exp_zero));
    check_eq({tag, ".msb"}, 32'(msb_flag), 32'(exp_msb));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".shift_en"}, 32'(reg_shift_en), 32'd0);
    check_eq({tag, ".store"}, 32'(reg_store_en), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".acc_out"}, 32'(acc_out), 32'd0);
    check_eq({tag, ".bit_count"}, 32'(bit_count), 32'd0);
    check_eq({tag, ".zero"}, 32'(zero_flag), 32'd1);
    check_eq({tag, ".msb"}, 32'(msb_flag), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; wb_en = 1'b0; stall = 1'b0; abort = 1'b0; bit_in = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rstn = 1'b1;

    run_op("a5", 1'b1, 8'hA5, -1, 0, -1, -1);
    run_op("zero_nowb", 1'b0, 8'h00, -1, 0, -1, -1);
    run_op("stall_ff", 1'b1, 8'hFF, 4, 3, -1, -1);
    run_op("abort_3c", 1'b1, 8'h3C, -1, 0, 5, -1);
    run_op("restart", 1'b1, 8'h5A, -1, 0, -1, 3);

    // Asynchronous reset in the middle of a shift.
    @(posedge clk); #1;
    start = 1'b1; wb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0; bit_in = 1'($urandom);
    end
    @(posedge clk); #1;
    bit_in = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_zero = 1'b1;
    exp_msb  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("post_rst.store", 32'(reg_store_en), 32'd0);
      check_eq("post_rst.done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 25; i++) begin
      int sa, sl, ao, ro;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      sl = int'($urandom_range(1, 4));
      ao = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      ro = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_op("rand", 1'($urandom), 8'($urandom), sa, sl, ao, ro);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
